// File: rtl/dtw_axis_pkg.sv
// Shared types and helpers for the DTW result AXI4-Stream output stage.
package dtw_axis_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } dtw_state_e;

  // Ceiling log2; clogb2(1) = 0.
  function automatic int unsigned clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/dtw_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty; no write-through when full.
module dtw_sync_fifo
  import dtw_axis_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [clogb2(DEPTH):0]     level
);

  localparam int unsigned AW = clogb2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;

  assign wr_ok_c = wr_en && !full;
  assign rd_ok_c = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok_c, rd_ok_c})
        2'b10: begin
          level <= level + LW'(1);
          full  <= (level == LW'(DEPTH - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - LW'(1);
          full  <= 1'b0;
          empty <= (level == LW'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dtw_result_axis_master.sv
// AXI4-Stream master framing buffered DTW result words into packets toward the DMA.
module dtw_result_axis_master
  import dtw_axis_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_FIFO_DEPTH         = 16,
  parameter int unsigned C_PKT_LEN_WIDTH      = 16,
  parameter int unsigned C_M_START_COUNT      = 32
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                dtw_fifo_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     dtw_fifo_din,
  input  logic                                dtw_fifo_last,
  output logic                                dtw_fifo_full,
  output logic [clogb2(C_FIFO_DEPTH):0]       dtw_fifo_level,
  input  logic [C_PKT_LEN_WIDTH-1:0]          pkt_len,
  output logic                                overflow,
  input  logic                                clr_overflow,
  output logic                                pkt_done,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int unsigned DW   = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned PW   = C_PKT_LEN_WIDTH;
  localparam int unsigned SC_W = clogb2(C_M_START_COUNT) + 1;

  dtw_state_e       state;
  logic [SC_W-1:0]  start_cnt;
  logic [PW-1:0]    ld_idx;
  logic [PW-1:0]    len_q;

  logic [DW:0]      head;
  logic             fifo_empty;
  logic             load_c;
  logic             hs_c;
  logic [PW-1:0]    len_eff_c;
  logic             last_c;

  dtw_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (M_AXIS_ACLK),
    .rst_n   (M_AXIS_ARESETN),
    .wr_en   (dtw_fifo_wren),
    .wr_data ({dtw_fifo_last, dtw_fifo_din}),
    .rd_en   (load_c),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (dtw_fifo_full),
    .level   (dtw_fifo_level)
  );

  assign M_AXIS_TSTRB = '1;

  assign hs_c   = M_AXIS_TVALID && M_AXIS_TREADY;
  assign load_c = (state != ST_INIT) && !fifo_empty && (!M_AXIS_TVALID || M_AXIS_TREADY);

  // Packet length is sampled only on the first beat so mid-packet changes are ignored.
  assign len_eff_c = (ld_idx == '0) ? ((pkt_len == '0) ? PW'(1) : pkt_len) : len_q;
  assign last_c    = head[DW] || (ld_idx == len_eff_c - PW'(1));

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state         <= ST_INIT;
      start_cnt     <= '0;
      ld_idx        <= '0;
      len_q         <= '0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      overflow      <= 1'b0;
      pkt_done      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (start_cnt == SC_W'(C_M_START_COUNT - 1)) state <= ST_IDLE;
          else start_cnt <= start_cnt + SC_W'(1);
        end
        ST_IDLE: if (load_c) state <= ST_SEND;
        ST_SEND: if (hs_c && M_AXIS_TLAST && !load_c) state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase

      if (load_c) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= head[DW-1:0];
        M_AXIS_TLAST  <= last_c;
        ld_idx        <= last_c ? '0 : ld_idx + PW'(1);
        if (ld_idx == '0) len_q <= len_eff_c;
      end else if (hs_c) begin
        M_AXIS_TVALID <= 1'b0;
      end

      pkt_done <= hs_c && M_AXIS_TLAST;

      // A drop wins over a same-cycle clear.
      if (dtw_fifo_wren && dtw_fifo_full) overflow <= 1'b1;
      else if (clr_overflow)              overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dtw_result_axis_master.sv
// Directed, self-checking bench for dtw_result_axis_master (default parameters).
module tb_dtw_result_axis_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wren;
  logic [31:0] din;
  logic        dlast;
  logic        full;
  logic [4:0]  level;
  logic [15:0] pkt_len;
  logic        ovf;
  logic        clr;
  logic        pkt_done;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;

  always #5 clk = ~clk;

  dtw_result_axis_master dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .dtw_fifo_wren  (wren),
    .dtw_fifo_din   (din),
    .dtw_fifo_last  (dlast),
    .dtw_fifo_full  (full),
    .dtw_fifo_level (level),
    .pkt_len        (pkt_len),
    .overflow       (ovf),
    .clr_overflow   (clr),
    .pkt_done       (pkt_done),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cnt = 0;
  logic [32:0] rx_q [$];

  typedef struct {
    logic        wren;
    logic [31:0] din;
    logic        last;
    logic        tready;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [4:0]  elev;
    logic        edone;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record a handshake for the coming edge, then advance to the next sampling point.
  task automatic tick();
    if (rst_n && tvalid && tready) rx_q.push_back({tlast, tdata});
    @(negedge clk);
    cyc++;
    if (pkt_done) done_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wren = 1'b0; clr = 1'b0; tready = 1'b0; dlast = 1'b0; din = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    done_cnt = 0;
    rx_q.delete();
  endtask

  task automatic wait_init();
    repeat (34) tick();
  endtask

  task automatic wr(input logic [31:0] d, input logic l);
    wren = 1'b1; din = d; dlast = l;
    tick();
    wren = 1'b0; dlast = 1'b0;
  endtask

  // Starting right after reset release: 3 writes at edges 5..7, TREADY high, pkt_len 0.
  task automatic init_run(input logic [31:0] base);
    int first;
    first = -1;
    tready = 1'b1;
    pkt_len = 16'd0;
    for (int k = 0; k < 60; k++) begin
      wren = (k >= 4 && k < 7);
      din  = base + 32'(k - 4);
      dlast = 1'b0;
      tick();
      if (tvalid && first < 0) first = cyc;
    end
    wren = 1'b0;
    chk("init_not_early", 64'(first >= 32), 64'd1);
    chk("init_not_late", 64'(first >= 32 && first <= 34), 64'd1);
    chk("init_beats", 64'(rx_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      chk("init_beat", 64'(rx_q[i]), 64'({1'b1, base + 32'(i)}));
  endtask

  initial begin
    rst_n = 1'b0;
    wren = 1'b0; din = '0; dlast = 1'b0; clr = 1'b0; tready = 1'b0; pkt_len = '0;

    tbl[0] = '{1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 5'd1, 1'b0};
    tbl[1] = '{1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b1, 32'hA000_0001, 1'b0, 5'd1, 1'b0};
    tbl[2] = '{1'b1, 32'hA000_0003, 1'b0, 1'b1, 1'b1, 32'hA000_0002, 1'b1, 5'd1, 1'b0};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA000_0002, 1'b1, 5'd1, 1'b0};
    tbl[4] = '{1'b1, 32'hA000_0004, 1'b1, 1'b0, 1'b1, 32'hA000_0002, 1'b1, 5'd2, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA000_0003, 1'b0, 5'd1, 1'b1};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA000_0004, 1'b1, 5'd0, 1'b0};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0, 1'b1};
    tbl[8] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 5'd0, 1'b0};

    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(ovf), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("tstrb", 64'(tstrb), 64'hF);

    // Start delay and first beats
    do_reset();
    init_run(32'h0000_0100);

    // Cycle-accurate table, pkt_len = 2
    pkt_len = 16'd2;
    for (int v = 0; v < 9; v++) begin
      wren = tbl[v].wren; din = tbl[v].din; dlast = tbl[v].last; tready = tbl[v].tready;
      tick();
      wren = 1'b0; dlast = 1'b0;
      chk($sformatf("tbl%0d_tvalid", v), 64'(tvalid), 64'(tbl[v].ev));
      if (tbl[v].ev) begin
        chk($sformatf("tbl%0d_tdata", v), 64'(tdata), 64'(tbl[v].ed));
        chk($sformatf("tbl%0d_tlast", v), 64'(tlast), 64'(tbl[v].el));
      end
      chk($sformatf("tbl%0d_level", v), 64'(level), 64'(tbl[v].elev));
      chk($sformatf("tbl%0d_pkt_done", v), 64'(pkt_done), 64'(tbl[v].edone));
    end

    // pkt_len = 4, 10 words
    do_reset(); wait_init();
    pkt_len = 16'd4; tready = 1'b1; rx_q.delete(); done_cnt = 0;
    for (int i = 0; i < 10; i++) wr(32'h200 + 32'(i), 1'b0);
    repeat (6) tick();
    chk("len4_beats", 64'(rx_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      chk($sformatf("len4_beat%0d", i + 1), 64'(rx_q[i]), 64'({(i == 3 || i == 7), 32'h200 + 32'(i)}));
    chk("len4_pkt_done", 64'(done_cnt), 64'd2);

    // Explicit end-of-packet flag restarts the count
    do_reset(); wait_init();
    pkt_len = 16'd8; tready = 1'b1; rx_q.delete(); done_cnt = 0;
    for (int i = 0; i < 12; i++) wr(32'h300 + 32'(i), (i == 2));
    repeat (6) tick();
    chk("eop_beats", 64'(rx_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++)
      chk($sformatf("eop_beat%0d", i + 1), 64'(rx_q[i]), 64'({(i == 2 || i == 10), 32'h300 + 32'(i)}));
    chk("eop_pkt_done", 64'(done_cnt), 64'd2);

    // Fill, overflow, stability, clear, drain
    do_reset(); wait_init();
    pkt_len = 16'd0; tready = 1'b0; rx_q.delete();
    for (int i = 0; i < 18; i++) wr(32'h400 + 32'(i), 1'b0);
    chk("ovf_full", 64'(full), 64'd1);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_tvalid", 64'(tvalid), 64'd1);
    repeat (3) tick();
    chk("ovf_tdata_stable", 64'(tdata), 64'h400);
    clr = 1'b1;
    wr(32'hDEAD, 1'b0);
    chk("ovf_clr_vs_drop", 64'(ovf), 64'd1);
    tick();
    clr = 1'b0;
    chk("ovf_cleared", 64'(ovf), 64'd0);
    chk("ovf_level_hold", 64'(level), 64'd16);
    tready = 1'b1;
    repeat (20) tick();
    chk("drain_beats", 64'(rx_q.size()), 64'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++)
      chk($sformatf("drain_beat%0d", i), 64'(rx_q[i][31:0]), 64'(32'h400 + 32'(i)));
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_full", 64'(full), 64'd0);

    // TREADY toggling
    do_reset(); wait_init();
    pkt_len = 16'd100; rx_q.delete();
    for (int i = 0; i < 80; i++) begin
      wren = (i < 20); din = 32'h500 + 32'(i); tready = i[0];
      tick();
    end
    wren = 1'b0;
    chk("tog_beats", 64'(rx_q.size()), 64'd20);
    for (int i = 0; i < 20 && i < rx_q.size(); i++)
      chk($sformatf("tog_beat%0d", i), 64'(rx_q[i][31:0]), 64'(32'h500 + 32'(i)));

    // Reset mid-packet
    do_reset(); wait_init();
    pkt_len = 16'd8; tready = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h600 + 32'(i), 1'b0);
    tick();
    chk("mid_tvalid_before", 64'(tvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_tvalid_async", 64'(tvalid), 64'd0);
    chk("mid_level_async", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0; done_cnt = 0; rx_q.delete();
    init_run(32'h0000_0700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
